// File: rtl/sram_sprite_loader.sv
// Sprite loader: packs a byte stream into 16-bit words (low byte first) and writes them to an
// asynchronous SRAM. Each write has a one-cycle address/data setup, a WE_CYCLES-long strobe
// and a one-cycle hold.
module sram_sprite_loader #(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,  // byte packing assumes exactly two bytes
  parameter int unsigned WE_CYCLES  = 2    // 1..15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_abort,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  input  logic [ADDR_WIDTH-1:0] i_word_count,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic [ADDR_WIDTH-1:0] o_sram_addr,
  output logic [DATA_WIDTH-1:0] o_sram_dq,
  output logic                  o_sram_we_n,
  output logic                  o_sram_ce_n,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [2:0] {
    StIdle,
    StLo,
    StHi,
    StSetup,
    StWrite,
    StHold,
    StFinish
  } state_e;

  localparam logic [3:0] WeLoad = 4'(WE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] dq_q, dq_d;
  logic [3:0]            we_cnt_q, we_cnt_d;

  logic ready_q, we_n_q, ce_n_q, busy_q, done_q;

  // Next-state, address/count and data packing.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    dq_d     = dq_q;
    we_cnt_d = we_cnt_q;

    if (state_q != StIdle && i_abort) begin
      // Abort wins over everything outside IDLE; any half-assembled word is dropped.
      state_d  = StIdle;
      we_cnt_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            addr_d  = i_base_addr;
            cnt_d   = i_word_count;
            state_d = (i_word_count == '0) ? StFinish : StLo;
          end
        end
        StLo: begin
          if (i_byte_valid) begin
            dq_d[7:0] = i_byte;
            state_d   = StHi;
          end
        end
        StHi: begin
          if (i_byte_valid) begin
            dq_d[15:8] = i_byte;
            state_d    = StSetup;
          end
        end
        StSetup: begin
          we_cnt_d = WeLoad;
          state_d  = StWrite;
        end
        StWrite: begin
          if (we_cnt_q == '0) begin
            state_d = StHold;
          end else begin
            we_cnt_d = we_cnt_q - 4'd1;
          end
        end
        StHold: begin
          cnt_d   = cnt_q - ADDR_WIDTH'(1);
          addr_d  = addr_q + ADDR_WIDTH'(1);  // wraps naturally at 2^ADDR_WIDTH
          state_d = (cnt_q == ADDR_WIDTH'(1)) ? StFinish : StLo;
        end
        StFinish: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // State, datapath and counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      cnt_q    <= '0;
      dq_q     <= '0;
      we_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      we_cnt_q <= we_cnt_d;
    end
  end

  // Control outputs registered from the next state so they line up with state_q.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ready_q <= 1'b0;
      we_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_d == StLo) || (state_d == StHi);
      we_n_q  <= (state_d != StWrite);
      ce_n_q  <= !((state_d == StSetup) || (state_d == StWrite) || (state_d == StHold));
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFinish);
    end
  end

  assign o_byte_ready = ready_q;
  assign o_sram_addr  = addr_q;
  assign o_sram_dq    = dq_q;
  assign o_sram_we_n  = we_n_q;
  assign o_sram_ce_n  = ce_n_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;

endmodule

// File: tb/tb_sram_sprite_loader.sv
// Directed bench for sram_sprite_loader: one instance per WE_CYCLES setting (2, 1, 4),
// sharing byte stream, abort and reset; each has its own start.
module tb_sram_sprite_loader;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_abort = 1'b0;
  logic [19:0] i_base_addr = '0;
  logic [19:0] i_word_count = '0;
  logic [7:0]  i_byte = '0;
  logic        i_byte_valid = 1'b0;
  logic        start0 = 1'b0, start1 = 1'b0, start4 = 1'b0;

  logic [19:0] addr0, addr1, addr4;
  logic [15:0] dq0, dq1, dq4;
  logic        we_n0, we_n1, we_n4, ce_n0, ce_n1, ce_n4;
  logic        ready0, ready1, ready4, busy0, busy1, busy4, done0, done1, done4;

  always #5 i_clk = ~i_clk;

  sram_sprite_loader #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WE_CYCLES(2)) u_dut0 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start0), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_word_count(i_word_count), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(ready0), .o_sram_addr(addr0),
    .o_sram_dq(dq0), .o_sram_we_n(we_n0), .o_sram_ce_n(ce_n0), .o_busy(busy0), .o_done(done0)
  );

  sram_sprite_loader #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WE_CYCLES(1)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start1), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_word_count(i_word_count), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(ready1), .o_sram_addr(addr1),
    .o_sram_dq(dq1), .o_sram_we_n(we_n1), .o_sram_ce_n(ce_n1), .o_busy(busy1), .o_done(done1)
  );

  sram_sprite_loader #(.ADDR_WIDTH(20), .DATA_WIDTH(16), .WE_CYCLES(4)) u_dut4 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(start4), .i_abort(i_abort),
    .i_base_addr(i_base_addr), .i_word_count(i_word_count), .i_byte(i_byte),
    .i_byte_valid(i_byte_valid), .o_byte_ready(ready4), .o_sram_addr(addr4),
    .o_sram_dq(dq4), .o_sram_we_n(we_n4), .o_sram_ce_n(ce_n4), .o_busy(busy4), .o_done(done4)
  );

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Write monitor state (sampled on the falling edge).
  int          cyc = 0;
  logic [19:0] wr_addr[$];
  logic [15:0] wr_dq[$];
  int          wr_len[$];
  int          wr_cyc[$];
  int          done_cnt0 = 0, done_cnt1 = 0, done_cnt4 = 0;
  int          unstable = 0;
  bit          in0 = 1'b0;
  logic [19:0] c_addr = '0;
  logic [15:0] c_dq = '0;
  int          c_len = 0;
  int          fall1[$];
  int          fall4[$];
  int          low1 = 0, low4 = 0;
  logic        prev1 = 1'b1, prev4 = 1'b1;

  always @(posedge i_clk) cyc <= cyc + 1;

  always @(negedge i_clk) begin
    if (!we_n0) begin
      if (!in0) begin
        in0 = 1'b1;
        c_addr = addr0;
        c_dq = dq0;
        c_len = 0;
        wr_cyc.push_back(cyc);
      end else if (addr0 !== c_addr || dq0 !== c_dq) begin
        unstable++;
      end
      c_len++;
    end else if (in0) begin
      in0 = 1'b0;
      wr_addr.push_back(c_addr);
      wr_dq.push_back(c_dq);
      wr_len.push_back(c_len);
    end
    if (done0) done_cnt0++;
    if (done1) done_cnt1++;
    if (done4) done_cnt4++;
    if (!we_n1) begin
      low1++;
      if (prev1) fall1.push_back(cyc);
    end
    prev1 = we_n1;
    if (!we_n4) begin
      low4++;
      if (prev4) fall4.push_back(cyc);
    end
    prev4 = we_n4;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next falling edge; drive and sample there.
  task automatic step(input int n);
    repeat (n) begin
      @(negedge i_clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    wr_addr.delete();
    wr_dq.delete();
    wr_len.delete();
    wr_cyc.delete();
    fall1.delete();
    fall4.delete();
    done_cnt0 = 0;
    done_cnt1 = 0;
    done_cnt4 = 0;
    low1 = 0;
    low4 = 0;
    unstable = 0;
  endtask

  // Present bytes in order, advancing only on a cycle where a loader accepted.
  task automatic feed(input logic [7:0] b[$], input bit toggle, input string tag);
    int   idx = 0;
    int   k = 0;
    logic acc;
    while (idx < b.size() && k < 200) begin
      i_byte = b[idx];
      i_byte_valid = toggle ? ((k % 2) == 0) : 1'b1;
      acc = (ready0 | ready1 | ready4) & i_byte_valid;
      step(1);
      if (acc) idx++;
      k++;
    end
    i_byte_valid = 1'b0;
    check(tag, idx, b.size());
  endtask

  function automatic logic busy_of(input int w);
    case (w)
      1:       return busy1;
      4:       return busy4;
      default: return busy0;
    endcase
  endfunction

  task automatic wait_idle(input int w, input string tag);
    int k = 0;
    while (busy_of(w) && k < 100) begin
      step(1);
      k++;
    end
    check(tag, busy_of(w), 1'b0);
  endtask

  task automatic start_load(input int w, input logic [19:0] base, input logic [19:0] cnt);
    i_base_addr = base;
    i_word_count = cnt;
    case (w)
      1:       start1 = 1'b1;
      4:       start4 = 1'b1;
      default: start0 = 1'b1;
    endcase
    step(1);
    start0 = 1'b0;
    start1 = 1'b0;
    start4 = 1'b0;
  endtask

  logic [7:0] bq[$];

  initial begin
    // Reset values
    step(2);
    check("rst_addr", addr0, 20'h0);
    check("rst_dq", dq0, 16'h0);
    check("rst_we_n", we_n0, 1'b1);
    check("rst_ce_n", ce_n0, 1'b1);
    check("rst_ready", ready0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    i_rst_n = 1'b1;
    step(1);
    clear_mon();

    // Basic two-word load, bytes always valid
    start_load(0, 20'h00100, 20'd2);
    check("t1_busy", busy0, 1'b1);
    check("t1_ready", ready0, 1'b1);
    bq = {8'h11, 8'h22, 8'h33, 8'h44};
    feed(bq, 1'b0, "t1_feed");
    wait_idle(0, "t1_idle");
    check("t1_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t1_addr0", wr_addr[0], 20'h00100);
      check("t1_dq0", wr_dq[0], 16'h2211);
      check("t1_len0", wr_len[0], 2);
      check("t1_addr1", wr_addr[1], 20'h00101);
      check("t1_dq1", wr_dq[1], 16'h4433);
      check("t1_len1", wr_len[1], 2);
      check("t1_spacing", wr_cyc[1] - wr_cyc[0], 6);
    end
    check("t1_done", done_cnt0, 1);
    check("t1_stable", unstable, 0);
    check("t1_ce_n", ce_n0, 1'b1);
    clear_mon();

    // Zero word count
    start_load(0, 20'h00ABC, 20'd0);
    check("t2_done", done0, 1'b1);
    check("t2_busy", busy0, 1'b1);
    check("t2_ready", ready0, 1'b0);
    step(1);
    check("t2_done_off", done0, 1'b0);
    check("t2_busy_off", busy0, 1'b0);
    step(2);
    check("t2_nwr", wr_cyc.size(), 0);
    check("t2_ndone", done_cnt0, 1);
    clear_mon();

    // Address wrap with toggling valid; a start mid-load must be ignored
    start_load(0, 20'hFFFFF, 20'd2);
    start_load(0, 20'h00123, 20'd7);
    bq = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    feed(bq, 1'b1, "t3_feed");
    wait_idle(0, "t3_idle");
    check("t3_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t3_addr0", wr_addr[0], 20'hFFFFF);
      check("t3_dq0", wr_dq[0], 16'hB2A1);
      check("t3_addr1", wr_addr[1], 20'h00000);
      check("t3_dq1", wr_dq[1], 16'hD4C3);
    end
    check("t3_done", done_cnt0, 1);
    clear_mon();

    // Abort in the first WRITE cycle of word 1 of 3
    start_load(0, 20'h00200, 20'd3);
    bq = {8'h55, 8'h66};
    feed(bq, 1'b0, "t4_feed");
    check("t4_setup_ce_n", ce_n0, 1'b0);
    check("t4_setup_we_n", we_n0, 1'b1);
    check("t4_setup_addr", addr0, 20'h00200);
    check("t4_setup_dq", dq0, 16'h6655);
    step(1);
    check("t4_write_we_n", we_n0, 1'b0);
    i_abort = 1'b1;
    step(1);
    i_abort = 1'b0;
    check("t4_abort_we_n", we_n0, 1'b1);
    check("t4_abort_ce_n", ce_n0, 1'b1);
    check("t4_abort_busy", busy0, 1'b0);
    step(3);
    check("t4_no_done", done_cnt0, 0);
    check("t4_partial_len", (wr_len.size() == 1) ? wr_len[0] : -1, 1);
    // start and abort together in IDLE: start wins
    i_abort = 1'b1;
    start_load(0, 20'h00300, 20'd1);
    i_abort = 1'b0;
    check("t4_restart_busy", busy0, 1'b1);
    bq = {8'h77, 8'h88};
    feed(bq, 1'b0, "t4_feed2");
    wait_idle(0, "t4_idle");
    check("t4_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t4_addr", wr_addr[1], 20'h00300);
      check("t4_dq", wr_dq[1], 16'h8877);
      check("t4_len", wr_len[1], 2);
    end
    check("t4_done", done_cnt0, 1);
    clear_mon();

    // Reset during HI, then during WRITE
    start_load(0, 20'h00400, 20'd2);
    bq = {8'h99};
    feed(bq, 1'b0, "t5_feed");
    check("t5_hi_ready", ready0, 1'b1);
    i_rst_n = 1'b0;
    #1;
    check("t5_addr", addr0, 20'h0);
    check("t5_dq", dq0, 16'h0);
    check("t5_we_n", we_n0, 1'b1);
    check("t5_ce_n", ce_n0, 1'b1);
    check("t5_ready", ready0, 1'b0);
    check("t5_busy", busy0, 1'b0);
    check("t5_done", done0, 1'b0);
    i_rst_n = 1'b1;
    i_byte_valid = 1'b1;
    step(3);
    i_byte_valid = 1'b0;
    check("t5_post_ready", ready0, 1'b0);
    check("t5_post_busy", busy0, 1'b0);
    start_load(0, 20'h00500, 20'd1);
    bq = {8'h01, 8'h02};
    feed(bq, 1'b0, "t5_feed2");
    step(1);
    check("t5_write_we_n", we_n0, 1'b0);
    i_rst_n = 1'b0;
    #1;
    check("t5_async_we_n", we_n0, 1'b1);
    check("t5_async_ce_n", ce_n0, 1'b1);
    i_rst_n = 1'b1;
    step(3);
    check("t5_no_done", done_cnt0, 0);
    clear_mon();

    // WE_CYCLES = 1 and 4 spacing
    start_load(1, 20'h00010, 20'd2);
    bq = {8'hE1, 8'hE2, 8'hE3, 8'hE4};
    feed(bq, 1'b0, "t6_feed1");
    wait_idle(1, "t6_idle1");
    check("t6_nfall1", fall1.size(), 2);
    if (fall1.size() == 2) check("t6_spacing1", fall1[1] - fall1[0], 5);
    check("t6_low1", low1, 2);
    check("t6_done1", done_cnt1, 1);
    check("t6_addr1", addr1, 20'h00012);
    start_load(4, 20'h00020, 20'd2);
    bq = {8'hF1, 8'hF2, 8'hF3, 8'hF4};
    feed(bq, 1'b0, "t6_feed4");
    wait_idle(4, "t6_idle4");
    check("t6_nfall4", fall4.size(), 2);
    if (fall4.size() == 2) check("t6_spacing4", fall4[1] - fall4[0], 8);
    check("t6_low4", low4, 8);
    check("t6_done4", done_cnt4, 1);
    check("t6_dq4", dq4, 16'hF4F3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
